mips_muldiv_ctrl: RTL

//   Sequencer that owns the HI/LO register pair of the MIPS ALU test chip.
//   - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests through a valid/ready handshake.
//   - Runs an iterative radix-2 shift-add multiply or restoring divide, one bit per cycle.
//   - Commits the result to HI/LO, which the datapath reads as test-chip HI/LOW.

---
 rtl/mips_muldiv_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_ctrl.sv
// mips_muldiv_ctrl: sequencer owning the HI/LO register pair.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a valid/ready handshake
// and runs an iterative radix-2 shift-add multiply or a restoring divide at
// one bit per cycle. The result is committed to HI/LO.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   req_valid/req_ready   request handshake (ready == controller idle)
//   req_funct             operation select (MIPS funct field)
//   req_a, req_b          rs / rt operands
//   flush                 synchronous abort of an in-flight operation
//   busy                  operation in flight
//   done                  one-cycle pulse when HI/LO were updated
//   div_zero              sticky divide-by-zero flag, cleared on next accept
//   bad_funct             one-cycle pulse after accepting an unlisted funct
//   hi, lo                HI / LO registers
module mips_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             bad_funct,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   opb;   // multiplicand or divisor magnitude
  // Shared accumulator: mult = {partial product, remaining multiplier bits},
  // div = {remainder, quotient/remaining dividend bits}.
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    signed_op = (req_funct == F_MULT) || (req_funct == F_DIV);
    a_neg     = signed_op & req_a[WIDTH-1];
    b_neg     = signed_op & req_b[WIDTH-1];
    a_mag     = a_neg ? ('0 - req_a) : req_a;
    b_mag     = b_neg ? ('0 - req_b) : req_b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

    div_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_sh >= {1'b0, opb});
    div_diff  = div_sh - {1'b0, opb};

    // Sign restoration: product/quotient negative when signs differ,
    // remainder follows the dividend. Most-negative / -1 falls out as
    // quotient = most-negative, remainder = 0.
    prod_fix  = (neg_a ^ neg_b) ? ('0 - acc) : acc;
    quo_fix   = (neg_a ^ neg_b) ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix   = neg_a ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      opb       <= '0;
      acc       <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      bad_funct <= 1'b0;
    end else begin
      done      <= 1'b0;
      bad_funct <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            div_zero <= 1'b0;
            case (req_funct)
              F_MULT, F_MULTU: begin
                neg_a  <= a_neg;
                neg_b  <= b_neg;
                opb    <= a_mag;
                acc    <= {{WIDTH{1'b0}}, b_mag};
                is_div <= 1'b0;
                cnt    <= CW'(WIDTH - 1);
                state  <= CALC;
              end
              F_DIV, F_DIVU: begin
                if (req_b == '0) begin
                  hi       <= req_a;
                  lo       <= '1;
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                  state    <= DONE;
                end else begin
                  neg_a  <= a_neg;
                  neg_b  <= b_neg;
                  opb    <= b_mag;
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  is_div <= 1'b1;
                  cnt    <= CW'(WIDTH - 1);
                  state  <= CALC;
                end
              end
              F_MTHI: begin
                hi    <= req_a;
                done  <= 1'b1;
                state <= DONE;
              end
              F_MTLO: begin
                lo    <= req_a;
                done  <= 1'b1;
                state <= DONE;
              end
              default: bad_funct <= 1'b1;
            endcase
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              if (div_ge)
                acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
              else
                acc <= {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            if (cnt == '0)
              state <= FIX;
            else
              cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi    <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo    <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
